// File: rtl/bit_population_generator_if.sv
// Handshake/bus bundle between a count producer and the bit population generator.
// Latency: none, wires only; WIDTH must match the attached generator.
// Backpressure: producer watches ready_o; with BPG_RANGE_ERR_EN defined the bundle also carries err_o.
interface bit_population_generator_if #(
    parameter int WIDTH = 7
);
    localparam int CW = $clog2(WIDTH) + 1;

    logic [CW-1:0]    cnt_i;
    logic             cnt_val_i;
    logic             ready_o;
    logic [WIDTH-1:0] data_o;
    logic             data_val_o;
    logic             busy_o;
`ifdef BPG_RANGE_ERR_EN
    logic             err_o;

    modport master (output cnt_i, cnt_val_i, input ready_o, data_o, data_val_o, busy_o, err_o);
    modport slave  (input cnt_i, cnt_val_i, output ready_o, data_o, data_val_o, busy_o, err_o);
`else
    modport master (output cnt_i, cnt_val_i, input ready_o, data_o, data_val_o, busy_o);
    modport slave  (input cnt_i, cnt_val_i, output ready_o, data_o, data_val_o, busy_o);
`endif
endinterface

// File: rtl/bit_population_generator.sv
// Serially builds a WIDTH-bit word holding cnt_i contiguous ones from bit 0, one bit per clock.
// Latency: data_val_o pulses k+1 cycles after the accept edge, k = min(cnt_i, WIDTH).
// Backpressure: ready_o low while generating, cnt_val_i ignored then; BPG_RANGE_ERR_EN rejects cnt_i > WIDTH via err_o.
module bit_population_generator #(
    parameter int WIDTH = 7
) (
    input  logic                       clk_i,
    input  logic                       arst_n_i,
    bit_population_generator_if.slave  bus
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam int IW = $clog2(WIDTH);
    localparam logic [CW-1:0] WIDTH_C = CW'(WIDTH);
    localparam logic [CW-1:0] ONE_C   = CW'(1);

    typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] data;
    logic             data_val;
    logic [IW-1:0]    idx;
    logic [CW-1:0]    rem;
    logic             accept;
    logic             over;
    logic             reject;
    logic [CW-1:0]    k;

    assign accept = bus.cnt_val_i && (state == IDLE);
    assign over   = bus.cnt_i > WIDTH_C;
    assign k      = over ? WIDTH_C : bus.cnt_i;

`ifdef BPG_RANGE_ERR_EN
    logic err_pend;
    logic err;

    assign reject    = over;
    assign bus.err_o = err;

    // Out-of-range rejection flag, delayed one extra flop so it lands where a k=0 result would.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            err_pend <= 1'b0;
            err      <= 1'b0;
        end else begin
            err_pend <= accept && over;
            err      <= err_pend;
        end
    end
`else
    assign reject = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: FILL lasts exactly k cycles, leaving on the edge where rem is 1.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept && !reject) begin
                    state_nxt = (k == '0) ? DONE : FILL;
                end
            end
            FILL: begin
                if (rem == ONE_C) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: idx is held on the final fill so it never goes past WIDTH-1.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            acc      <= '0;
            data     <= '0;
            data_val <= 1'b0;
            idx      <= '0;
            rem      <= '0;
        end else begin
            data_val <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept && !reject) begin
                        acc <= '0;
                        idx <= '0;
                        rem <= k;
                    end
                end
                FILL: begin
                    acc[idx] <= 1'b1;
                    rem      <= rem - ONE_C;
                    if (rem != ONE_C) begin
                        idx <= idx + IW'(1);
                    end
                end
                DONE: begin
                    data     <= acc;
                    data_val <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.ready_o    = (state == IDLE);
    assign bus.busy_o     = (state != IDLE);
    assign bus.data_o     = data;
    assign bus.data_val_o = data_val;

endmodule

// File: tb/tb_bit_population_generator.sv
// Directed bench for bit_population_generator with WIDTH=7 (BPG_RANGE_ERR_EN optional).
// Latency: checks data_val_o arrives k+1 cycles after the accept edge.
// Backpressure: checks ready_o/busy_o windows, ignored mid-generation requests and async reset.
module tb_bit_population_generator;
    localparam int W  = 7;
    localparam int CW = $clog2(W) + 1;

    logic clk;
    logic arst_n;
    int   checks;
    int   errors;

    bit_population_generator_if #(.WIDTH(W)) bus ();

    bit_population_generator #(.WIDTH(W)) dut (
        .clk_i    (clk),
        .arst_n_i (arst_n),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [CW-1:0] cnt;
        logic [W-1:0]  data;
        int            lat;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Starts at a negedge; returns how many edges until data_val_o is seen and how many of those had ready_o low.
    task automatic wait_pulse(output int m, output int low);
        m   = 0;
        low = 0;
        while (!bus.data_val_o && m < 40) begin
            if (!bus.ready_o) low++;
            @(negedge clk);
            m++;
        end
        check("pulse_seen", 32'(bus.data_val_o), 32'd1);
    endtask

    function automatic int popcount(input logic [W-1:0] v);
        int n = 0;
        for (int i = 0; i < W; i++) if (v[i]) n++;
        return n;
    endfunction

    task automatic run_one(input string nm, input logic [CW-1:0] c, input logic [W-1:0] exp_d,
                           input int exp_lat, output logic [W-1:0] got);
        int m;
        int low;
        @(negedge clk);
        check({nm, "_ready_pre"}, 32'(bus.ready_o), 32'd1);
        bus.cnt_i     = c;
        bus.cnt_val_i = 1'b1;
        @(negedge clk);
        bus.cnt_val_i = 1'b0;
        wait_pulse(m, low);
        check({nm, "_lat"}, 32'(m), 32'(exp_lat));
        check({nm, "_ready_low"}, 32'(low), 32'(exp_lat));
        check({nm, "_data"}, 32'(bus.data_o), 32'(exp_d));
        check({nm, "_ready_at_pulse"}, 32'(bus.ready_o), 32'd1);
        check({nm, "_busy_at_pulse"}, 32'(bus.busy_o), 32'd0);
        got = bus.data_o;
        @(negedge clk);
        check({nm, "_pulse_width"}, 32'(bus.data_val_o), 32'd0);
        check({nm, "_data_hold"}, 32'(bus.data_o), 32'(exp_d));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] got;
        int           m;
        int           low;
        int           pulses;
        int           c;

        checks = 0;
        errors = 0;

        vecs[0] = '{cnt: 4'd3, data: 7'b0000111, lat: 4};
        vecs[1] = '{cnt: 4'd0, data: 7'b0000000, lat: 1};
        vecs[2] = '{cnt: 4'd7, data: 7'b1111111, lat: 8};
`ifdef BPG_RANGE_ERR_EN
        vecs[3] = '{cnt: 4'd4, data: 7'b0001111, lat: 5};
`else
        vecs[3] = '{cnt: 4'd9, data: 7'b1111111, lat: 8};
`endif
        vecs[4] = '{cnt: 4'd1, data: 7'b0000001, lat: 2};
        vecs[5] = '{cnt: 4'd5, data: 7'b0011111, lat: 6};

        arst_n        = 1'b0;
        bus.cnt_i     = '0;
        bus.cnt_val_i = 1'b0;
        #1;
        check("rst_ready", 32'(bus.ready_o), 32'd1);
        check("rst_busy", 32'(bus.busy_o), 32'd0);
        check("rst_data", 32'(bus.data_o), 32'd0);
        check("rst_data_val", 32'(bus.data_val_o), 32'd0);
`ifdef BPG_RANGE_ERR_EN
        check("rst_err", 32'(bus.err_o), 32'd0);
`endif
        #20;
        @(negedge clk);
        arst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            run_one($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].data, vecs[i].lat, got);
        end

        // Back-to-back: a different count held during generation must be ignored.
        @(negedge clk);
        bus.cnt_i     = 4'd2;
        bus.cnt_val_i = 1'b1;
        @(negedge clk);
        bus.cnt_i = 4'd6;
        wait_pulse(m, low);
        check("b2b_first_lat", 32'(m), 32'd3);
        check("b2b_first_data", 32'(bus.data_o), 32'h03);
        bus.cnt_i = 4'd5;
        @(negedge clk);
        bus.cnt_val_i = 1'b0;
        check("b2b_busy_after_accept", 32'(bus.busy_o), 32'd1);
        wait_pulse(m, low);
        check("b2b_second_lat", 32'(m), 32'd6);
        check("b2b_second_data", 32'(bus.data_o), 32'h1F);
        @(negedge clk);

`ifdef BPG_RANGE_ERR_EN
        // Out-of-range count is rejected: err_o pulse, no result, ready_o stays high.
        bus.cnt_i     = 4'd9;
        bus.cnt_val_i = 1'b1;
        @(negedge clk);
        bus.cnt_val_i = 1'b0;
        check("err_ready0", 32'(bus.ready_o), 32'd1);
        check("err_early", 32'(bus.err_o), 32'd0);
        @(negedge clk);
        check("err_pulse", 32'(bus.err_o), 32'd1);
        check("err_no_val", 32'(bus.data_val_o), 32'd0);
        check("err_ready1", 32'(bus.ready_o), 32'd1);
        @(negedge clk);
        check("err_clear", 32'(bus.err_o), 32'd0);
        check("err_data_kept", 32'(bus.data_o), 32'h1F);
        check("err_no_val2", 32'(bus.data_val_o), 32'd0);
`endif

        // Async reset between edges during FILL of cnt_i=6.
        bus.cnt_i     = 4'd6;
        bus.cnt_val_i = 1'b1;
        @(negedge clk);
        bus.cnt_val_i = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        check("mid_busy_before_rst", 32'(bus.busy_o), 32'd1);
        arst_n = 1'b0;
        #1;
        check("arst_ready", 32'(bus.ready_o), 32'd1);
        check("arst_busy", 32'(bus.busy_o), 32'd0);
        check("arst_data", 32'(bus.data_o), 32'd0);
        check("arst_data_val", 32'(bus.data_val_o), 32'd0);
        @(negedge clk);
        arst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.data_val_o) pulses++;
        end
        check("arst_no_pulse", 32'(pulses), 32'd0);
        run_one("post_rst", 4'd1, 7'b0000001, 2, got);

        // Loopback through a population count model.
        for (int i = 0; i < 10; i++) begin
            c = (i < 8) ? i : int'($urandom_range(0, 7));
            run_one($sformatf("loop%0d", i), CW'(c), W'((1 << c) - 1), c + 1, got);
            check($sformatf("loop%0d_popcount", i), 32'(popcount(got)), 32'(c));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
